snake_board_renderer: RTL and testbench

//  Read-side consumer of the snake board RAM: scans the 32x16 cell board through the RAM's read-only port and renders it as 640x480@60 VGA.

---
 rtl/snake_board_renderer_pkg.sv | 58 +++++
 rtl/snake_board_renderer_if.sv | 29 ++
 rtl/snake_board_renderer_vga_timing.sv | 65 ++++++
 rtl/snake_board_renderer.sv | 153 +++++++++++++++
 tb/tb_snake_board_renderer.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/snake_board_renderer_pkg.sv
// Shared constants, types and the cell palette for the snake board VGA renderer.
package snake_vga_pkg;

    localparam int H_VISIBLE = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

    localparam int V_VISIBLE = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;
    localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam int CELL_PX = 20;
    localparam int BOARD_W = 32;
    localparam int BOARD_H = 16;

    localparam int CNT_W    = $clog2((H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL);
    localparam int RAM_X_W  = 5;
    localparam int RAM_Y_W  = 4;
    localparam int CODE_W   = 4;

    localparam logic [CODE_W-1:0] CELL_EMPTY = 4'd0;
    localparam logic [CODE_W-1:0] CELL_BODY  = 4'd1;
    localparam logic [CODE_W-1:0] CELL_HEAD  = 4'd2;
    localparam logic [CODE_W-1:0] CELL_FOOD  = 4'd3;
    localparam logic [CODE_W-1:0] CELL_WALL  = 4'd4;

    // Colours are packed {r[2:0], g[2:0], b[1:0]}.
    localparam logic [7:0] RGB_BLACK = 8'b000_000_00;
    localparam logic [7:0] GRID_RGB  = 8'b001_001_01;

    // Control bits travelling down the pixel pipeline; syncs are active low.
    typedef struct packed {
        logic hsync_n;
        logic vsync_n;
        logic region;
        logic frame_start;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '{hsync_n: 1'b1, vsync_n: 1'b1, region: 1'b0, frame_start: 1'b0};

    function automatic logic [7:0] palette(input logic [CODE_W-1:0] code);
        logic [7:0] rgb;
        case (code)
            CELL_EMPTY: rgb = RGB_BLACK;
            CELL_BODY:  rgb = {3'b000, 3'b110, 2'b00};
            CELL_HEAD:  rgb = {3'b111, 3'b111, 2'b00};
            CELL_FOOD:  rgb = {3'b111, 3'b000, 2'b00};
            CELL_WALL:  rgb = {3'b100, 3'b100, 2'b10};
            default:    rgb = {3'b111, 3'b000, 2'b11};
        endcase
        return rgb;
    endfunction

endpackage

// File: rtl/snake_board_renderer_if.sv
// Board-RAM read port plus VGA pin bundle; master is the renderer, slave the RAM/pins side.
interface snake_board_renderer_if;
    import snake_vga_pkg::RAM_X_W;
    import snake_vga_pkg::RAM_Y_W;
    import snake_vga_pkg::CODE_W;

    logic [RAM_X_W-1:0] ram_x;
    logic [RAM_Y_W-1:0] ram_y;
    logic [CODE_W-1:0]  ram_data;
    logic               vga_hsync;
    logic               vga_vsync;
    logic [2:0]         vga_r;
    logic [2:0]         vga_g;
    logic [1:0]         vga_b;
    logic               frame_tick;

    modport master (
        output ram_x, ram_y,
        input  ram_data,
        output vga_hsync, vga_vsync, vga_r, vga_g, vga_b, frame_tick
    );

    modport slave (
        input  ram_x, ram_y,
        output ram_data,
        input  vga_hsync, vga_vsync, vga_r, vga_g, vga_b, frame_tick
    );

endinterface

// File: rtl/snake_board_renderer_vga_timing.sv
// Raster counters for the VGA frame and the stage-0 decodes derived from them.
module vga_timing #(
    parameter int H_VISIBLE = snake_vga_pkg::H_VISIBLE,
    parameter int H_FRONT   = snake_vga_pkg::H_FRONT,
    parameter int H_SYNC    = snake_vga_pkg::H_SYNC,
    parameter int H_BACK    = snake_vga_pkg::H_BACK,
    parameter int V_VISIBLE = snake_vga_pkg::V_VISIBLE,
    parameter int V_FRONT   = snake_vga_pkg::V_FRONT,
    parameter int V_SYNC    = snake_vga_pkg::V_SYNC,
    parameter int V_BACK    = snake_vga_pkg::V_BACK
) (
    input  logic                            clk,
    input  logic                            rst,
    output logic [snake_vga_pkg::CNT_W-1:0] h_o,
    output logic [snake_vga_pkg::CNT_W-1:0] v_o,
    output logic                            line_end_o,
    output logic                            frame_end_o,
    output logic                            hsync_n_o,
    output logic                            vsync_n_o,
    output logic                            visible_o,
    output logic                            frame_start_o
);
    import snake_vga_pkg::CNT_W;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_VISIBLE + H_FRONT);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_VISIBLE + V_FRONT);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [CNT_W-1:0] h_q, h_d;
    logic [CNT_W-1:0] v_q, v_d;

    always_comb begin
        h_d = h_q + CNT_W'(1);
        v_d = v_q;
        if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    assign h_o           = h_q;
    assign v_o           = v_q;
    assign line_end_o    = (h_q == H_LAST);
    assign frame_end_o   = (h_q == H_LAST) && (v_q == V_LAST);
    assign hsync_n_o     = !((h_q >= HS_START) && (h_q < HS_END));
    assign vsync_n_o     = !((v_q >= VS_START) && (v_q < VS_END));
    assign visible_o     = (h_q < H_VIS) && (v_q < V_VIS);
    assign frame_start_o = (h_q == '0) && (v_q == V_VIS);

endmodule

// File: rtl/snake_board_renderer.sv
// Scans the 32x16 board RAM and renders it as VGA with a fixed 2-cycle pixel pipeline.
// Optional GRID_LINES_EN: draws dark-grey grid lines on empty cells along cell edges.
module snake_board_renderer #(
    parameter int H_VISIBLE = snake_vga_pkg::H_VISIBLE,
    parameter int H_FRONT   = snake_vga_pkg::H_FRONT,
    parameter int H_SYNC    = snake_vga_pkg::H_SYNC,
    parameter int H_BACK    = snake_vga_pkg::H_BACK,
    parameter int V_VISIBLE = snake_vga_pkg::V_VISIBLE,
    parameter int V_FRONT   = snake_vga_pkg::V_FRONT,
    parameter int V_SYNC    = snake_vga_pkg::V_SYNC,
    parameter int V_BACK    = snake_vga_pkg::V_BACK,
    parameter int CELL_PX   = snake_vga_pkg::CELL_PX
) (
    input  logic                   clk,
    input  logic                   rst,
    snake_board_renderer_if.master bus
);
    import snake_vga_pkg::CNT_W;
    import snake_vga_pkg::BOARD_W;
    import snake_vga_pkg::BOARD_H;
    import snake_vga_pkg::RAM_X_W;
    import snake_vga_pkg::RAM_Y_W;
    import snake_vga_pkg::RGB_BLACK;
    import snake_vga_pkg::ctrl_t;
    import snake_vga_pkg::CTRL_IDLE;
    import snake_vga_pkg::palette;
`ifdef GRID_LINES_EN
    import snake_vga_pkg::GRID_RGB;
    import snake_vga_pkg::CELL_EMPTY;
`endif

    localparam int               PX_W     = $clog2(CELL_PX);
    localparam logic [PX_W-1:0]  PX_LAST  = PX_W'(CELL_PX - 1);
    localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] BOARD_XE = CNT_W'(BOARD_W * CELL_PX);
    localparam logic [CNT_W-1:0] BOARD_YE = CNT_W'(BOARD_H * CELL_PX);

    logic [CNT_W-1:0] h_s0, v_s0;
    logic             line_end, frame_end, visible_s0;
    ctrl_t            ctrl_s0, ctrl_s1_q;

    vga_timing #(
        .H_VISIBLE(H_VISIBLE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
        .V_VISIBLE(V_VISIBLE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK)
    ) u_timing (
        .clk          (clk),
        .rst          (rst),
        .h_o          (h_s0),
        .v_o          (v_s0),
        .line_end_o   (line_end),
        .frame_end_o  (frame_end),
        .hsync_n_o    (ctrl_s0.hsync_n),
        .vsync_n_o    (ctrl_s0.vsync_n),
        .visible_o    (visible_s0),
        .frame_start_o(ctrl_s0.frame_start)
    );

    assign ctrl_s0.region = visible_s0 && (h_s0 < BOARD_XE) && (v_s0 < BOARD_YE);

    // Pixel-within-cell and cell counters replace a divide by CELL_PX.
    logic [PX_W-1:0]    px_q, px_d, py_q, py_d;
    logic [RAM_X_W-1:0] cx_q, cx_d;
    logic [RAM_Y_W-1:0] cy_q, cy_d;

    always_comb begin
        px_d = px_q;
        cx_d = cx_q;
        py_d = py_q;
        cy_d = cy_q;
        if (line_end) begin
            px_d = '0;
            cx_d = '0;
        end else if (h_s0 < H_VIS) begin
            if (px_q == PX_LAST) begin
                px_d = '0;
                cx_d = cx_q + RAM_X_W'(1);
            end else begin
                px_d = px_q + PX_W'(1);
            end
        end
        if (frame_end) begin
            py_d = '0;
            cy_d = '0;
        end else if (line_end && (v_s0 < BOARD_YE)) begin
            if (py_q == PX_LAST) begin
                py_d = '0;
                cy_d = cy_q + RAM_Y_W'(1);
            end else begin
                py_d = py_q + PX_W'(1);
            end
        end
    end

    assign bus.ram_x = ctrl_s0.region ? cx_q : '0;
    assign bus.ram_y = ctrl_s0.region ? cy_q : '0;

    logic [7:0] rgb_q, rgb_d;
    logic       hsync_q, vsync_q, frame_tick_q;
`ifdef GRID_LINES_EN
    logic       grid_s1_q;
`endif

    always_comb begin
        rgb_d = RGB_BLACK;
        if (ctrl_s1_q.region) begin
            rgb_d = palette(bus.ram_data);
`ifdef GRID_LINES_EN
            if (grid_s1_q && (bus.ram_data == CELL_EMPTY)) begin
                rgb_d = GRID_RGB;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            px_q         <= '0;
            cx_q         <= '0;
            py_q         <= '0;
            cy_q         <= '0;
            ctrl_s1_q    <= CTRL_IDLE;
            rgb_q        <= RGB_BLACK;
            hsync_q      <= 1'b1;
            vsync_q      <= 1'b1;
            frame_tick_q <= 1'b0;
`ifdef GRID_LINES_EN
            grid_s1_q    <= 1'b0;
`endif
        end else begin
            px_q         <= px_d;
            cx_q         <= cx_d;
            py_q         <= py_d;
            cy_q         <= cy_d;
            ctrl_s1_q    <= ctrl_s0;
            rgb_q        <= rgb_d;
            hsync_q      <= ctrl_s1_q.hsync_n;
            vsync_q      <= ctrl_s1_q.vsync_n;
            frame_tick_q <= ctrl_s1_q.frame_start;
`ifdef GRID_LINES_EN
            // Only the edge flag is carried, which is all the grid decision needs.
            grid_s1_q    <= (px_q == '0) || (py_q == '0);
`endif
        end
    end

    assign bus.vga_r      = rgb_q[7:5];
    assign bus.vga_g      = rgb_q[4:2];
    assign bus.vga_b      = rgb_q[1:0];
    assign bus.vga_hsync  = hsync_q;
    assign bus.vga_vsync  = vsync_q;
    assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_snake_board_renderer.sv
// Renderer bench: shrunken raster (4-px cells, 144x72 total) so whole frames fit a short run;
// every cycle the pins and RAM address are compared with a pixel-index arithmetic model.
module tb_snake_board_renderer;

    localparam int HV = 128, HF = 4, HS = 8, HB = 4;
    localparam int VV = 66,  VF = 2, VS = 2, VB = 2;
    localparam int CP = 4;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam int BPW = 32 * CP;
    localparam int BPH = 16 * CP;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   k = 0;
    int   ticks = 0;
    logic [3:0] board [32][16];

    always #20 clk = ~clk;

    snake_board_renderer_if bus ();

    snake_board_renderer #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .CELL_PX(CP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Board RAM with one cycle of read latency.
    always @(posedge clk) bus.ram_data <= board[bus.ram_x][bus.ram_y];

    function automatic logic [7:0] cell_colour(input logic [3:0] code);
        case (code)
            4'd0:    return 8'b000_000_00;
            4'd1:    return 8'b000_110_00;
            4'd2:    return 8'b111_111_00;
            4'd3:    return 8'b111_000_00;
            4'd4:    return 8'b100_100_10;
            default: return 8'b111_000_11;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            if (bad <= 20) $error("FAIL %s k=%0d got=%0h exp=%0h", tag, k, got, exp);
        end
    endtask

    // k = counter index since reset; the pins show pixel index k-2.
    task automatic step();
        int n, h, v, h0, v0, ax, ay;
        logic [7:0] rgb;
        logic hs, vs, tk;
        logic [3:0] code;
        @(posedge clk);
        if (rst) k = 0; else k++;
        #1;
        if (bus.frame_tick === 1'b1) ticks++;
        h0 = k % HT;
        v0 = (k / HT) % VT;
        ax = 0;
        ay = 0;
        if (h0 < BPW && v0 < BPH) begin
            ax = h0 / CP;
            ay = v0 / CP;
        end
        rgb = 8'h00; hs = 1'b1; vs = 1'b1; tk = 1'b0;
        if (k >= 2) begin
            n = k - 2;
            h = n % HT;
            v = (n / HT) % VT;
            hs = !(h >= HV + HF && h < HV + HF + HS);
            vs = !(v >= VV + VF && v < VV + VF + VS);
            tk = (h == 0 && v == VV);
            if (h < BPW && v < BPH) begin
                code = board[h / CP][v / CP];
                rgb = cell_colour(code);
`ifdef GRID_LINES_EN
                if (code == 4'd0 && (h % CP == 0 || v % CP == 0)) rgb = 8'b001_001_01;
`endif
            end
        end
        check("rgb",   {24'd0, bus.vga_r, bus.vga_g, bus.vga_b}, {24'd0, rgb});
        check("hsync", {31'd0, bus.vga_hsync}, {31'd0, hs});
        check("vsync", {31'd0, bus.vga_vsync}, {31'd0, vs});
        check("tick",  {31'd0, bus.frame_tick}, {31'd0, tk});
        check("ram_x", {27'd0, bus.ram_x}, 32'(ax));
        check("ram_y", {28'd0, bus.ram_y}, 32'(ay));
    endtask

    task automatic wait_for(input int th, input int tv);
        int budget;
        for (budget = 0; budget < 2 * FRAME; budget++) begin
            if (k % HT == th && (k / HT) % VT == tv) break;
            step();
        end
        check("wait_reached", {31'd0, (k % HT == th && (k / HT) % VT == tv)}, 32'd1);
    endtask

    initial begin
        foreach (board[i, j]) board[i][j] = 4'd0;
        board[5][3]   = 4'd2;
        board[31][15] = 4'd3;
        board[0][0]   = 4'd9;

        rst = 1'b1;
        repeat (5) step();
        rst = 1'b0;
        ticks = 0;
        repeat (FRAME) step();
        check("ticks_frame1", 32'(ticks), 32'd1);
        $display("frame1 done: total=%0d bad=%0d", total, bad);

        wait_for(0, VV + 2);
        foreach (board[i, j]) board[i][j] = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
        ticks = 0;
        repeat (FRAME) step();
        check("ticks_frame2", 32'(ticks), 32'd1);
        $display("random frame done: total=%0d bad=%0d", total, bad);

        wait_for(60, 40);
        rst = 1'b1;
        step();
        rst = 1'b0;
        ticks = 0;
        repeat (VV * HT + 1) step();
        check("no_tick_after_rst", 32'(ticks), 32'd0);
        repeat (2) step();
        check("tick_after_rst", 32'(ticks), 32'd1);
        $display("mid-frame reset done: total=%0d bad=%0d", total, bad);

        wait_for(0, VV + 2);
        foreach (board[i, j]) board[i][j] = 4'd0;
        ticks = 0;
        repeat (FRAME) step();
        check("ticks_empty", 32'(ticks), 32'd1);
        $display("empty frame done: total=%0d bad=%0d", total, bad);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
